// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch_pkg
//  Brief   : Opcode constants and FSM state encoding for the fetch unit.
//  Revision: 1.0
// ============================================================================
package instr_fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module  : next_pc_calc
//  Brief   : Combinational sequential/jump/branch target selection.
//  Revision: 1.0
// ============================================================================
module next_pc_calc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        pc_src,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
    // Sign-extended word offset; the 32-bit add wraps naturally for negative offsets.
    assign branch_target = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (pc_src) begin
            if (ir[31:26] == OP_J) begin
                next_pc = jump_target;
            end else begin
                next_pc = branch_target;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch
//  Brief   : Two-state fetch/execute sequencer holding PC, IR and retire count.
//  Revision: 1.0
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        pc_src,
    input  logic        exec_done,
    output logic [31:0] retired_count
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;

    next_pc_calc u_next_pc_calc (
        .pc      (pc_q),
        .ir      (ir_q),
        .pc_src  (pc_src),
        .next_pc (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Handshake outputs are masked by rst directly so they drop in the reset cycle itself.
    assign imem_req      = (state_q == ST_FETCH) && !rst;
    assign instr_valid   = (state_q == ST_EXEC) && !rst;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = ir_q;
    assign opcode        = ir_q[31:26];
    assign func          = ir_q[5:0];
    assign retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_instr_fetch
//  Brief   : Directed and randomized checks of instr_fetch against a behavioural model.
//  Revision: 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] pc;
    logic        pc_src = 1'b0;
    logic        exec_done = 1'b0;
    logic [31:0] retired_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: "fetching" flag plus architectural PC/IR/count.
    bit          m_known = 1'b0;
    bit          m_fetching;
    logic [31:0] m_pc, m_ir, m_ret;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .instr         (instr),
        .opcode        (opcode),
        .func          (func),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_src        (pc_src),
        .exec_done     (exec_done),
        .retired_count (retired_count)
    );

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w, input bit src);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        if (!src) return seq;
        if (w[31:26] == 6'd2) return (seq & 32'hF000_0000) | (32'(w[25:0]) << 2);
        off = int'($signed(w[15:0]));
        return seq + 32'(off * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_known    = 1'b1;
            m_fetching = 1'b1;
            m_pc       = 32'h0;
            m_ir       = 32'h0;
            m_ret      = 32'h0;
        end else if (m_known) begin
            if (m_fetching) begin
                if (imem_ack) begin
                    m_ir       = imem_rdata;
                    m_fetching = 1'b0;
                end
            end else if (exec_done) begin
                m_pc       = ref_next(m_pc, m_ir, pc_src);
                m_ret      = m_ret + 32'd1;
                m_fetching = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        if (m_known) begin
            chk("imem_req",      {31'b0, imem_req},    {31'b0, m_fetching && !rst});
            chk("instr_valid",   {31'b0, instr_valid}, {31'b0, !m_fetching && !rst});
            chk("imem_addr",     imem_addr,     m_pc);
            chk("pc",            pc,            m_pc);
            chk("instr",         instr,         m_ir);
            chk("opcode",        {26'b0, opcode}, {26'b0, m_ir[31:26]});
            chk("func",          {26'b0, func},   {26'b0, m_ir[5:0]});
            chk("retired_count", retired_count, m_ret);
        end
    endtask

    // One clock: compare on the falling edge, then advance the model on the rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic fetch_exec(input logic [31:0] word, input bit src);
        imem_ack = 1'b1; imem_rdata = word;
        cyc();
        imem_ack = 1'b0;
        exec_done = 1'b1; pc_src = src;
        cyc();
        exec_done = 1'b0; pc_src = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_req",  {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr,         32'h0);

        // Slow fetch: three cycles without ack, then ack
        for (int i = 0; i < 3; i++) begin
            chk("wait_addr", imem_addr,         32'h0);
            chk("wait_req",  {31'b0, imem_req}, 32'd1);
            cyc();
        end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        cyc();
        imem_ack = 1'b0;
        chk("first_valid",  {31'b0, instr_valid}, 32'd1);
        chk("first_opcode", {26'b0, opcode},      32'h08);
        chk("first_pc",     pc,                   32'h0);

        // Spurious ack during EXEC
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        chk("spur_ack_ir",  instr,         32'h2008_0005);
        chk("spur_ack_pc",  pc,            32'h0);
        chk("spur_ack_ret", retired_count, 32'd0);

        exec_done = 1'b1; pc_src = 1'b1;
        cyc();
        chk("br_fwd_addr", imem_addr,     32'h18);
        chk("br_fwd_ret",  retired_count, 32'd1);

        // Spurious exec_done during FETCH
        cyc();
        exec_done = 1'b0; pc_src = 1'b0;
        chk("spur_done_pc",  imem_addr,         32'h18);
        chk("spur_done_ret", retired_count,     32'd1);
        chk("spur_done_req", {31'b0, imem_req}, 32'd1);

        fetch_exec(32'h1000_0009, 1'b1);
        chk("to_40", imem_addr, 32'h40);
        fetch_exec(32'h1000_FFFE, 1'b1);
        chk("beq_back", imem_addr, 32'h3C);
        fetch_exec(32'h1000_0000, 1'b1);
        chk("back_40", imem_addr, 32'h40);
        fetch_exec(32'h1000_FFFE, 1'b0);
        chk("beq_nt", imem_addr, 32'h44);
        fetch_exec(32'h0BFF_FFFF, 1'b1);
        chk("j_max", imem_addr, 32'h0FFF_FFFC);
        fetch_exec(32'h0000_0000, 1'b0);
        chk("seq_1000", imem_addr, 32'h1000_0000);
        fetch_exec(32'h0800_0010, 1'b1);
        chk("j_region", imem_addr,     32'h1000_0040);
        chk("ret_8",    retired_count, 32'd8);

        // Wrap-around via negative branch from 0, then sequential wrap
        rst = 1'b1; cyc(); rst = 1'b0; #1;
        chk("rst2_ret", retired_count, 32'd0);
        fetch_exec(32'h1000_FFFE, 1'b1);
        chk("neg_wrap", imem_addr, 32'hFFFF_FFFC);
        fetch_exec(32'h0000_0000, 1'b0);
        chk("seq_wrap",     imem_addr,     32'h0);
        chk("seq_wrap_ret", retired_count, 32'd2);

        // Reset coincident with exec_done discards the instruction
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        imem_ack = 1'b0;
        rst = 1'b1; exec_done = 1'b1; pc_src = 1'b1;
        cyc();
        rst = 1'b0; exec_done = 1'b0; pc_src = 1'b0;
        #1;
        chk("rst_exec_ret",   retired_count,        32'd0);
        chk("rst_exec_pc",    imem_addr,            32'h0);
        chk("rst_exec_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_exec_ir",    instr,                32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            imem_ack  = ($urandom_range(0, 2) == 0);
            exec_done = ($urandom_range(0, 2) == 0);
            pc_src    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       imem_rdata = {6'b000010, 26'($urandom)};
                1:       imem_rdata = {6'b000100, 26'($urandom)};
                2:       imem_rdata = {6'b000101, 26'($urandom)};
                default: imem_rdata = $urandom;
            endcase
            cyc();
        end
        rst = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
